// File: rtl/commit_stage.sv
// Writeback/commit stage: register file, F1/F2 flags, PC, branch redirect.
// Ports: clock/reset, in_valid/in_ready handshake, ALU results in, read ports out.
module commit_stage #(
  parameter int          NREGS        = 16,
  parameter int          AW           = 4,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    instr,
  input  logic [AW-1:0] rd,
  input  logic [31:0]   C,
  input  logic          F3,
  input  logic          addrch,
  input  logic [31:0]   naddr,
  input  logic [AW-1:0] rs_a,
  input  logic [AW-1:0] rs_b,
  output logic [31:0]   rd_a,
  output logic [31:0]   rd_b,
  output logic [31:0]   reg8,
  output logic          F1,
  output logic          F2,
  output logic [31:0]   pc,
  output logic          redirect,
  output logic [31:0]   redirect_pc
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];
  logic        f1_q, f1_d;
  logic        f2_q, f2_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        accept;
  logic        is_wr;
  logic        is_flag;
  logic        is_br;
  logic        wr_en;
  logic        taken;

  assign accept = in_valid & in_ready;

  // opcode classes; 6,7 and >=16 fall through as no-ops
  always_comb begin
    is_wr   = 1'b0;
    is_flag = 1'b0;
    is_br   = 1'b0;
    unique case (1'b1)
      (instr <= 6'd5):                    is_wr   = 1'b1;
      (instr >= 6'd8 && instr <= 6'd13):  is_flag = 1'b1;
      (instr == 6'd14 || instr == 6'd15): is_br   = 1'b1;
      default: ;
    endcase
  end

  assign wr_en = accept & is_wr & (rd != '0);
  assign taken = accept & is_br & addrch;

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (taken) begin
          state_d = FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // outputs of the FSM
  always_comb begin
    in_ready = (state_q == RUN);
  end

  // architectural state update
  always_comb begin
    regs_d        = regs_q;
    f1_d          = f1_q;
    f2_d          = f2_q;
    pc_d          = pc_q;
    redirect_d    = taken;
    redirect_pc_d = redirect_pc_q;
    if (wr_en) begin
      regs_d[rd] = C;
    end
    if (accept) begin
      if (is_flag) begin
        f2_d = f1_q;
        f1_d = F3;
      end
      if (taken) begin
        pc_d          = naddr;
        redirect_pc_d = naddr;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q        <= '{default: '0};
      f1_q          <= 1'b0;
      f2_q          <= 1'b0;
      pc_q          <= RESET_PC;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      regs_q        <= regs_d;
      f1_q          <= f1_d;
      f2_q          <= f2_d;
      pc_q          <= pc_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // write-first read ports; index 0 is hardwired zero
  always_comb begin
    rd_a = regs_q[rs_a];
    if (rs_a == '0) begin
      rd_a = 32'd0;
    end else if (wr_en && rd == rs_a) begin
      rd_a = C;
    end
    rd_b = regs_q[rs_b];
    if (rs_b == '0) begin
      rd_b = 32'd0;
    end else if (wr_en && rd == rs_b) begin
      rd_b = C;
    end
    reg8 = regs_q[8];
    if (wr_en && rd == AW'(8)) begin
      reg8 = C;
    end
  end

  assign F1          = f1_q;
  assign F2          = f2_q;
  assign pc          = pc_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_commit_stage.sv
// Directed self-checking bench for commit_stage.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_commit_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  instr;
  logic [3:0]  rd;
  logic [31:0] C;
  logic        F3;
  logic        addrch;
  logic [31:0] naddr;
  logic [3:0]  rs_a;
  logic [3:0]  rs_b;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [31:0] reg8;
  logic        F1;
  logic        F2;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks;
  int errors;

  commit_stage #(
    .NREGS(16),
    .AW(4),
    .RESET_PC(32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr(instr),
    .rd(rd),
    .C(C),
    .F3(F3),
    .addrch(addrch),
    .naddr(naddr),
    .rs_a(rs_a),
    .rs_b(rs_b),
    .rd_a(rd_a),
    .rd_b(rd_b),
    .reg8(reg8),
    .F1(F1),
    .F2(F2),
    .pc(pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [3:0] d,
                       input logic [31:0] c, input logic br,
                       input logic [31:0] tgt);
    in_valid = 1'b1;
    instr    = op;
    rd       = d;
    C        = c;
    addrch   = br;
    naddr    = tgt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(6'd0, 4'd3, 32'd5, 1'b0, 32'd0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    rs_a     = 4'd3;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b exp 1", in_ready);
    end
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h exp 0", pc);
    end
    checks++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_redirect: got %b/%h exp 0/0", redirect, redirect_pc);
    end
    checks++;
    if (rd_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_reg3: got %h exp 0", rd_a);
    end
    checks++;
    if (F1 !== 1'b0 || F2 !== 1'b0 || reg8 !== 32'h0) begin
      errors++;
      $display("FAIL reset_flags: got %b%b %h exp 00 0", F1, F2, reg8);
    end
  endtask

  task automatic test_write();
    drive(6'd0, 4'd3, 32'h0000_00AA, 1'b0, 32'd0);
    rs_a = 4'd0;
    rs_b = 4'd3;
    #1;
    checks++;
    if (rd_b !== 32'hAA) begin
      errors++;
      $display("FAIL bypass_b: got %h exp aa", rd_b);
    end
    checks++;
    if (rd_a !== 32'h0) begin
      errors++;
      $display("FAIL rs0_read: got %h exp 0", rd_a);
    end
    tick();
    in_valid = 1'b0;
    rs_a     = 4'd3;
    #1;
    checks++;
    if (rd_a !== 32'hAA) begin
      errors++;
      $display("FAIL write_r3: got %h exp aa", rd_a);
    end
    checks++;
    if (pc !== 32'h4) begin
      errors++;
      $display("FAIL write_pc: got %h exp 4", pc);
    end
  endtask

  task automatic test_rd0();
    drive(6'd1, 4'd0, 32'hDEAD_BEEF, 1'b0, 32'd0);
    rs_a = 4'd0;
    #1;
    checks++;
    if (rd_a !== 32'h0) begin
      errors++;
      $display("FAIL rd0_bypass: got %h exp 0", rd_a);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (rd_a !== 32'h0 || pc !== 32'h8) begin
      errors++;
      $display("FAIL rd0_write: got %h pc %h exp 0 pc 8", rd_a, pc);
    end
  endtask

  task automatic test_reg8();
    drive(6'd2, 4'd8, 32'h1234_5678, 1'b0, 32'd0);
    #1;
    checks++;
    if (reg8 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reg8_bypass: got %h exp 12345678", reg8);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (reg8 !== 32'h1234_5678 || pc !== 32'hC) begin
      errors++;
      $display("FAIL reg8_held: got %h pc %h exp 12345678 pc c", reg8, pc);
    end
  endtask

  task automatic test_nowrite();
    drive(6'd6, 4'd5, 32'h0000_FFFF, 1'b0, 32'd0);
    tick();
    drive(6'd20, 4'd5, 32'h0000_EEEE, 1'b1, 32'h0000_0400);
    tick();
    in_valid = 1'b0;
    rs_a     = 4'd5;
    #1;
    checks++;
    if (rd_a !== 32'h0 || redirect !== 1'b0 || pc !== 32'h14) begin
      errors++;
      $display("FAIL noop: got r5 %h redir %b pc %h exp 0 0 14",
               rd_a, redirect, pc);
    end
    drive(6'd3, 4'd5, 32'h0000_0055, 1'b1, 32'h0000_0400);
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (rd_a !== 32'h55 || redirect !== 1'b0 || pc !== 32'h18 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL addrch_ignored: got r5 %h redir %b pc %h rdy %b exp 55 0 18 1",
               rd_a, redirect, pc, in_ready);
    end
  endtask

  task automatic test_flags();
    drive(6'd8, 4'd3, 32'h0000_0999, 1'b0, 32'd0);
    F3 = 1'b1;
    tick();
    checks++;
    if (F1 !== 1'b1 || F2 !== 1'b0) begin
      errors++;
      $display("FAIL flag_first: got F1 %b F2 %b exp 1 0", F1, F2);
    end
    drive(6'd9, 4'd3, 32'h0000_0999, 1'b0, 32'd0);
    F3 = 1'b0;
    tick();
    in_valid = 1'b0;
    rs_a     = 4'd3;
    #1;
    checks++;
    if (F1 !== 1'b0 || F2 !== 1'b1) begin
      errors++;
      $display("FAIL flag_second: got F1 %b F2 %b exp 0 1", F1, F2);
    end
    checks++;
    if (rd_a !== 32'hAA || pc !== 32'h20) begin
      errors++;
      $display("FAIL flag_nowrite: got r3 %h pc %h exp aa 20", rd_a, pc);
    end
  endtask

  task automatic test_branch();
    drive(6'd14, 4'd4, 32'd0, 1'b1, 32'h0000_0100);
    tick();
    drive(6'd0, 4'd4, 32'h0000_0077, 1'b0, 32'd0);
    checks++;
    if (pc !== 32'h100 || redirect !== 1'b1 || redirect_pc !== 32'h100) begin
      errors++;
      $display("FAIL br_taken: got pc %h redir %b rpc %h exp 100 1 100",
               pc, redirect, redirect_pc);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL br_flush1: got %b exp 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || redirect !== 1'b0 || pc !== 32'h100) begin
      errors++;
      $display("FAIL br_flush2: got rdy %b redir %b pc %h exp 0 0 100",
               in_ready, redirect, pc);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || pc !== 32'h100) begin
      errors++;
      $display("FAIL br_resume: got rdy %b pc %h exp 1 100", in_ready, pc);
    end
    in_valid = 1'b0;
    rs_a     = 4'd4;
    #1;
    checks++;
    if (rd_a !== 32'h0) begin
      errors++;
      $display("FAIL br_no_accept: got r4 %h exp 0", rd_a);
    end
    drive(6'd15, 4'd4, 32'd0, 1'b0, 32'h0000_0200);
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h104 || redirect !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL br_not_taken: got pc %h redir %b rdy %b exp 104 0 1",
               pc, redirect, in_ready);
    end
  endtask

  task automatic test_wrap();
    drive(6'd15, 4'd0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    tick();
    in_valid = 1'b0;
    checks++;
    if (pc !== 32'hFFFF_FFFC || redirect_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_target: got pc %h rpc %h exp fffffffc", pc, redirect_pc);
    end
    tick();
    checks++;
    if (redirect !== 1'b0) begin
      errors++;
      $display("FAIL wrap_redir_drop: got %b exp 0", redirect);
    end
    tick();
    drive(6'd0, 4'd6, 32'd1, 1'b0, 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: got %h exp 0", pc);
    end
  endtask

  task automatic test_flush_reset();
    drive(6'd14, 4'd0, 32'd0, 1'b1, 32'h0000_0103);
    tick();
    in_valid = 1'b0;
    checks++;
    if (pc !== 32'h103 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL unaligned_pc: got pc %h rdy %b exp 103 0", pc, in_ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || pc !== 32'h0 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL flush_reset: got rdy %b pc %h redir %b exp 1 0 0",
               in_ready, pc, redirect);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    instr    = 6'd0;
    rd       = 4'd0;
    C        = 32'd0;
    F3       = 1'b0;
    addrch   = 1'b0;
    naddr    = 32'd0;
    rs_a     = 4'd0;
    rs_b     = 4'd0;
    test_reset();
    test_write();
    test_rd0();
    test_reg8();
    test_nowrite();
    test_flags();
    test_branch();
    test_wrap();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_stage.md
Name: commit_stage

Overview:
- Writeback/commit stage directly downstream of the ALU. Consumes the ALU result C, flag F3, branch request addrch and target naddr.
- Owns the architectural register file, the F1/F2 flag registers and the program counter.
- Feeds operands back to the ALU: the A/B read ports, reg8 and F1/F2.
- Accepts one instruction per cycle through a valid/ready handshake. Stalls for a fixed flush window after a taken branch.

Parameters:
- NREGS, 16, number of 32-bit architectural registers; register 0 reads as zero.
- AW, 4, register index width (log2 NREGS).
- RESET_PC, 32'h0000_0000, program counter value after reset.
- FLUSH_CYCLES, 2, cycles in_ready is held low after a taken branch (range 1..7).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  upstream presents an executed instruction this cycle.
- in_ready  out  1  stage can accept; transfer happens when in_valid & in_ready.
- instr  in  6  opcode that was fed to the ALU.
- rd  in  AW  destination register index.
- C  in  32  ALU result.
- F3  in  1  ALU flag result.
- addrch  in  1  ALU branch-taken request.
- naddr  in  32  ALU branch target.
- rs_a, rs_b  in  AW  read indices for ALU operands A and B.
- rd_a, rd_b  out  32  read data for A and B.
- reg8  out  32  current contents of register 8.
- F1, F2  out  1  flag registers.
- pc  out  32  committed program counter.
- redirect  out  1  one-cycle pulse when a branch is taken.
- redirect_pc  out  32  target PC, valid while redirect=1.

Behaviour:
- Reset (synchronous, active-high, at the clock edge):
  - All registers 0; F1=F2=0; pc=RESET_PC; redirect=0; redirect_pc=0.
  - FSM to RUN with flush counter 0; in_ready=1 in the first cycle after reset.
  - Reset overrides any accept or flush in the same cycle.
- Accept = in_valid & in_ready. Nothing changes state without accept, except the flush counter in FLUSH.
- FSM states:
  - RUN: in_ready=1.
  - FLUSH: in_ready=0; counter counts down from FLUSH_CYCLES. Returns to RUN on the edge where counter==1, so in_ready is low for exactly FLUSH_CYCLES cycles.
- Per-opcode effect on accept (all at the same edge):
  - instr 0..5: regs[rd] <= C unless rd==0 (write dropped); pc <= pc+4.
  - instr 6, 7: no register or flag write; pc <= pc+4.
  - instr 8..13: F2 <= old F1; F1 <= F3; no register write; pc <= pc+4.
  - instr 14, 15:
    - addrch=1: pc <= naddr; redirect <= 1 and redirect_pc <= naddr for exactly the next cycle; state <= FLUSH.
    - addrch=0: pc <= pc+4.
  - instr >= 16: treated as no-op; pc <= pc+4.
- addrch is ignored for opcodes other than 14/15.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). A naddr with bits[1:0] != 0 is committed unchanged.
- Read ports are combinational with write-first bypass:
  - If accept writes index k this cycle and rs_a==k (k != 0), rd_a = C. Same rule for rd_b.
  - rs==0 always returns 0.
- reg8 has the same bypass (rd==8 write shows C in the same cycle).
- F1/F2 outputs are registered; no bypass of F3.
- redirect is registered and deasserts after one cycle even if the next cycle is not an accept. in_valid during FLUSH is ignored: no accept.
- A reset during FLUSH aborts the flush; in_ready=1 the next cycle.

Test Plan:
- Reset with in_valid=1, instr=0, rd=3, C=5 asserted in the same cycle -> after the edge regs[3]=0, pc=0, in_ready=1, redirect=0.
- Accept instr=0, rd=3, C=32'h0000_00AA, then rs_a=3 -> rd_a=AA; pc advances 0->4. In that accept cycle with rs_b=3 -> rd_b=AA via bypass.
- Accept instr=1, rd=0, C=32'hDEAD_BEEF -> rd_a with rs_a=0 stays 0; pc+4.
- Accept instr=8 with F3=1, then instr=9 with F3=0 -> after the first edge F1=1, F2=0; after the second F1=0, F2=1. No register changes.
- Accept instr=14, addrch=1, naddr=32'h0000_0100 with FLUSH_CYCLES=2 -> pc=100 next cycle; redirect=1 for one cycle with redirect_pc=100; in_ready=0 for exactly 2 cycles with in_valid held high (no accepts), then 1. Repeat with addrch=0 -> pc+4, no redirect.
- Set pc to FFFF_FFFC via branch, then accept instr=0 -> pc=0. Assert reset in the first FLUSH cycle -> in_ready=1 and pc=RESET_PC next cycle.
